fadd_unit: RTL

FADD_UNIT -- requirements
Module: fadd_unit

---
 rtl/fpu_pkg.sv | 14 +
 rtl/fadd.sv | 112 +++++++++++
 rtl/fadd_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared single-precision FP types and constants.
package fpu_pkg;

    localparam int EXP_W         = 8;
    localparam int MAN_W         = 23;
    localparam int FADD_UNIT_LAT = 2;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } float32_t;

endpackage

// File: rtl/fadd.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even,
// full subnormal support. ovf flags a finite sum that rounded to infinity.
module fadd
    import fpu_pkg::*;
(
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y,
    output logic        ovf
);

    // hidden bit + fraction + guard, round, sticky
    localparam int GW = MAN_W + 4;
    localparam logic [GW-1:0] G_ONE = GW'(1);

    float32_t        fa, fb, fl, fs;
    logic            a_nan, b_nan, a_inf, b_inf;
    logic [9:0]      el, es, d, e_n, e_r, sh;
    logic [GW-1:0]   ml, ms, ms_sh, lost_mask, sn;
    logic [GW:0]     s;
    logic [4:0]      lz;
    logic [MAN_W+1:0] m_r;
    logic            rnd, hid;
    logic [MAN_W-1:0] frac;

    // Align, add/subtract, normalise (clamped at the subnormal floor), round.
    always_comb begin
        fa        = x1;
        fb        = x2;
        a_nan     = (fa.exp == '1) && (fa.man != '0);
        b_nan     = (fb.exp == '1) && (fb.man != '0);
        a_inf     = (fa.exp == '1) && (fa.man == '0);
        b_inf     = (fb.exp == '1) && (fb.man == '0);
        // larger magnitude first so the difference is never negative
        if (fb[30:0] > fa[30:0]) begin
            fl = fb;
            fs = fa;
        end else begin
            fl = fa;
            fs = fb;
        end
        el        = (fl.exp == '0) ? 10'd1 : {2'b00, fl.exp};
        es        = (fs.exp == '0) ? 10'd1 : {2'b00, fs.exp};
        ml        = {(fl.exp != '0), fl.man, 3'b000};
        ms        = {(fs.exp != '0), fs.man, 3'b000};
        d         = el - es;
        lost_mask = '0;
        if (d >= 10'(GW)) begin
            ms_sh = {{(GW-1){1'b0}}, |ms};
        end else begin
            lost_mask = (G_ONE << d) - G_ONE;
            ms_sh     = (ms >> d) | {{(GW-1){1'b0}}, |(ms & lost_mask)};
        end
        if (fl.sign == fs.sign) s = {1'b0, ml} + {1'b0, ms_sh};
        else                    s = {1'b0, ml} - {1'b0, ms_sh};

        lz = '0;
        for (int i = 0; i < GW; i++)
            if (s[i]) lz = 5'(GW - 1 - i);
        sh = '0;
        if (s[GW]) begin
            sn  = {s[GW:2], s[1] | s[0]};
            e_n = el + 10'd1;
        end else begin
            sh  = ({5'd0, lz} > (el - 10'd1)) ? (el - 10'd1) : {5'd0, lz};
            sn  = s[GW-1:0] << sh;
            e_n = el - sh;
        end

        rnd = sn[2] & (sn[1] | sn[0] | sn[3]);
        m_r = {1'b0, sn[GW-1:3]} + {{(MAN_W+1){1'b0}}, rnd};
        if (m_r[MAN_W+1]) begin
            e_r  = e_n + 10'd1;
            hid  = 1'b1;
            frac = m_r[MAN_W:1];
        end else begin
            e_r  = e_n;
            hid  = m_r[MAN_W];
            frac = m_r[MAN_W-1:0];
        end

        ovf = 1'b0;
        if (s == '0) begin
            // exact cancellation gives +0; -0 only when both inputs are -0
            y = {fl.sign & fs.sign, 31'd0};
        end else if (e_r >= 10'd255) begin
            y   = {fl.sign, 8'hff, 23'd0};
            ovf = 1'b1;
        end else begin
            y = {fl.sign, hid ? e_r[7:0] : 8'h00, frac};
        end

        // NaN/Inf operands override the datapath; NaNs are returned quieted
        if (a_nan) begin
            y   = x1 | 32'h0040_0000;
            ovf = 1'b0;
        end else if (b_nan) begin
            y   = x2 | 32'h0040_0000;
            ovf = 1'b0;
        end else if (a_inf && b_inf && (fa.sign != fb.sign)) begin
            y   = 32'h7fc0_0000;
            ovf = 1'b0;
        end else if (a_inf) begin
            y   = x1;
            ovf = 1'b0;
        end else if (b_inf) begin
            y   = x2;
            ovf = 1'b0;
        end
    end

endmodule

// File: rtl/fadd_unit.sv
// Two-stage pipelined wrapper around fadd with valid/ready handshakes,
// destination tag, per-result and sticky overflow, and busy tracking.
// Optional build macro FADD_UNIT_SUB_EN: op_sub = 1 computes x1 - x2.
module fadd_unit
    import fpu_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      x1,
    input  logic [31:0]      x2,
    input  logic             op_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      y,
    output logic [TAG_W-1:0] out_tag,
    output logic             ovf,
    output logic             ovf_sticky,
    input  logic             ovf_clr,
    output logic             busy
);

    logic             s1_valid, s2_valid;
    float32_t         s1_x1, s1_x2, x2_eff;
    logic [TAG_W-1:0] s1_tag;
    logic [31:0]      f_y;
    logic             f_ovf;
    logic [1:0]       count;
    logic             s2_adv, acc, xfer;

    assign s2_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_adv;
    assign acc       = in_valid && in_ready;
    assign xfer      = s2_valid && out_ready;
    assign out_valid = s2_valid;
    assign busy      = (count != 2'd0);

`ifdef FADD_UNIT_SUB_EN
    // Subtract folds into the adder by flipping the second operand's sign.
    always_comb begin
        x2_eff = x2;
        if (op_sub) x2_eff.sign = ~x2[31];
    end
`else
    logic unused_op_sub;
    assign unused_op_sub = op_sub;

    // Add-only build: operand passes straight through.
    always_comb begin
        x2_eff = x2;
    end
`endif

    // S1 operand register; reloads whenever it is empty or draining into S2.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_x1    <= '0;
            s1_x2    <= '0;
            s1_tag   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_x1  <= x1;
                s1_x2  <= x2_eff;
                s1_tag <= in_tag;
            end
        end
    end

    fadd u_fadd (
        .x1  (s1_x1),
        .x2  (s1_x2),
        .y   (f_y),
        .ovf (f_ovf)
    );

    // S2 result register; frozen while the downstream stalls.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s2_valid <= 1'b0;
            y        <= '0;
            ovf      <= 1'b0;
            out_tag  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                y       <= f_y;
                ovf     <= f_ovf;
                out_tag <= s1_tag;
            end
        end
    end

    // Outstanding-operation count (0..2) behind busy.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= 2'd0;
        end else begin
            case ({acc, xfer})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow: set on transfer of an overflowed result, set beats clear.
    always_ff @(posedge clk) begin
        if (!rstn)              ovf_sticky <= 1'b0;
        else if (xfer && ovf)   ovf_sticky <= 1'b1;
        else if (ovf_clr)       ovf_sticky <= 1'b0;
    end

endmodule
